// File: rtl/fp_norm_round.sv
// Normalise-and-round stage of the half-precision adder: shift to hidden-bit position, RNE rounding, ovf/unf.
// Optional macro FPN_DENORM_EN keeps denormal results on underflow instead of flushing to signed zero.
module fp_norm_round #(
  parameter int MW = 12,
  parameter int EW = 5,
  parameter int FW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] m_in,
  input  logic [3:0]    lead_pos,
  input  logic          in_zero,
  input  logic [EW-1:0] exp_in,
  input  logic          sign_in,
  input  logic          g_in,
  input  logic          s_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] exp_out,
  output logic [FW-1:0] frac_out,
  output logic          sign_out,
  output logic          ovf,
  output logic          unf
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  state_t state_reg, state_next;

  logic [MW-1:0] m_reg;
  logic [3:0]    lead_reg;
  logic          zero_reg;
  logic [EW-1:0] exp_reg;
  logic          sign_reg;
  logic          g_reg;
  logic          s_reg;

  // Normalised mantissa keeps the hidden bit; exponent carries one spare bit for overflow.
  logic [FW:0]   nm_reg, nm_next;
  logic [EW:0]   ne_reg, ne_next;
  logic          ng_reg, ng_next;
  logic          ns_reg, ns_next;
  logic          nunf_reg, nunf_next;
  logic          nden_reg, nden_next;

  logic [EW-1:0] exp_next;
  logic [FW-1:0] frac_next;
  logic          ovf_next;
  logic          unf_next;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == OUT);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = NORM;
      NORM:    state_next = ROUND;
      ROUND:   state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every possible left-shift result; the guard bit enters at bit 0 on the first shift.
  logic [MW-1:0] shx;
  logic [FW:0]   shl [0:FW];

  assign shx    = {m_reg[FW:0], g_reg};
  assign shl[0] = m_reg[FW:0];

  generate
    for (genvar gi = 1; gi <= FW; gi++) begin : g_shl
      logic [MW-1:0] shifted;
      assign shifted = shx << (gi - 1);
      assign shl[gi] = shifted[FW:0];
    end
  endgenerate

  logic [3:0] k;
  assign k = 4'(FW) - lead_reg;

`ifdef FPN_DENORM_EN
  logic [3:0] dsh;
  assign dsh = (exp_reg == '0) ? 4'd0 : 4'(exp_reg - 5'd1);
`endif

  always_comb begin
    nm_next   = m_reg[FW:0];
    ne_next   = {1'b0, exp_reg};
    ng_next   = g_reg;
    ns_next   = s_reg;
    nunf_next = 1'b0;
    nden_next = 1'b0;
    if (zero_reg) begin
      nm_next = '0;
      ne_next = '0;
      ng_next = 1'b0;
      ns_next = 1'b0;
    end else if (lead_reg >= 4'd11) begin
      nm_next = m_reg[MW-1:1];
      ne_next = {1'b0, exp_reg} + 6'd1;
      ng_next = m_reg[0];
      ns_next = g_reg | s_reg;
    end else if (lead_reg < 4'd10) begin
      if ({1'b0, exp_reg} <= {2'b0, k}) begin
`ifdef FPN_DENORM_EN
        nm_next   = shl[dsh];
        ne_next   = '0;
        nden_next = 1'b1;
        if (dsh != 4'd0) begin
          ng_next = 1'b0;
          ns_next = 1'b0;
        end
`else
        nm_next   = '0;
        ne_next   = '0;
        ng_next   = 1'b0;
        ns_next   = 1'b0;
        nunf_next = 1'b1;
`endif
      end else begin
        nm_next = shl[k];
        ne_next = {1'b0, exp_reg} - {2'b0, k};
        ng_next = 1'b0;
        ns_next = 1'b0;
      end
    end
  end

  logic          inc;
  logic [FW:0]   fsum;
  logic [EW:0]   rexp;
  logic          tiny;

  assign inc  = ng_reg & (ns_reg | nm_reg[0]);
  assign fsum = {1'b0, nm_reg[FW-1:0]} + {{FW{1'b0}}, inc};
  assign rexp = ne_reg + {{EW{1'b0}}, fsum[FW]};
  // A denormal that rounds up into the hidden bit becomes the smallest normal.
  assign tiny = ~nm_reg[FW] & ~fsum[FW];

  always_comb begin
    exp_next  = rexp[EW-1:0];
    frac_next = fsum[FW-1:0];
    ovf_next  = 1'b0;
    unf_next  = nunf_reg | (nden_reg & tiny);
    if (rexp >= {1'b0, {EW{1'b1}}}) begin
      exp_next  = {EW{1'b1}};
      frac_next = '0;
      ovf_next  = 1'b1;
      unf_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      m_reg     <= '0;
      lead_reg  <= '0;
      zero_reg  <= 1'b0;
      exp_reg   <= '0;
      sign_reg  <= 1'b0;
      g_reg     <= 1'b0;
      s_reg     <= 1'b0;
      nm_reg    <= '0;
      ne_reg    <= '0;
      ng_reg    <= 1'b0;
      ns_reg    <= 1'b0;
      nunf_reg  <= 1'b0;
      nden_reg  <= 1'b0;
      exp_out   <= '0;
      frac_out  <= '0;
      sign_out  <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && in_valid) begin
        m_reg    <= m_in;
        lead_reg <= lead_pos;
        zero_reg <= in_zero;
        exp_reg  <= exp_in;
        sign_reg <= sign_in;
        g_reg    <= g_in;
        s_reg    <= s_in;
      end
      if (state_reg == NORM) begin
        nm_reg   <= nm_next;
        ne_reg   <= ne_next;
        ng_reg   <= ng_next;
        ns_reg   <= ns_next;
        nunf_reg <= nunf_next;
        nden_reg <= nden_next;
      end
      if (state_reg == ROUND) begin
        exp_out  <= exp_next;
        frac_out <= frac_next;
        sign_out <= sign_reg;
        ovf      <= ovf_next;
        unf      <= unf_next;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed and random checks of fp_norm_round against an integer reference model of normalise + RNE.
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] m_in = '0;
  logic [3:0]  lead_pos = '0;
  logic        in_zero = 1'b0;
  logic [4:0]  exp_in = '0;
  logic        sign_in = 1'b0;
  logic        g_in = 1'b0;
  logic        s_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  exp_out;
  logic [9:0]  frac_out;
  logic        sign_out;
  logic        ovf;
  logic        unf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_norm_round dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .m_in(m_in), .lead_pos(lead_pos), .in_zero(in_zero), .exp_in(exp_in),
    .sign_in(sign_in), .g_in(g_in), .s_in(s_in), .out_valid(out_valid),
    .out_ready(out_ready), .exp_out(exp_out), .frac_out(frac_out),
    .sign_out(sign_out), .ovf(ovf), .unf(unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Value is tracked as mantissa*4 + guard*2 + sticky and renormalised with plain arithmetic.
  function automatic void ref_model(input int m, input int lead, input int z, input int e,
                                    input int g, input int s,
                                    output int eo, output int fo, output int ov, output int un);
    int full, k, mant, ex, den;
    ov = 0; un = 0; den = 0; k = 0;
    if (z != 0) begin
      eo = 0; fo = 0;
      return;
    end
    full = m * 4 + g * 2 + s;
    if (lead == 11) begin
      full = (full >> 1) | (full & 1);
      ex = e + 1;
    end else if (lead == 10) begin
      ex = e;
    end else begin
      k = 10 - lead;
      if (e <= k) begin
`ifdef FPN_DENORM_EN
        k = (e > 0) ? e - 1 : 0;
        den = 1;
        ex = 0;
`else
        eo = 0; fo = 0; un = 1;
        return;
`endif
      end else begin
        ex = e - k;
      end
      if (k > 0) full = (m * 4 + g * 2) << k;
    end
    mant = full >> 2;
    if ((((full >> 1) & 1) != 0) && (((full & 1) != 0) || ((mant & 1) != 0))) mant++;
    if (mant >= 2048) begin
      mant = mant >> 1;
      ex++;
    end
    if (den != 0) begin
      ex = (mant >= 1024) ? 1 : 0;
      un = (ex == 0) ? 1 : 0;
    end
    if (ex >= 31) begin
      eo = 31; fo = 0; ov = 1; un = 0;
    end else begin
      eo = ex; fo = mant & 1023;
    end
  endfunction

  task automatic do_op(input logic [11:0] m, input logic [3:0] lead, input logic z,
                       input logic [4:0] e, input logic sg, input logic g, input logic s,
                       input int hold);
    int eo, fo, ov, un;
    ref_model(int'(m), int'(lead), int'(z), int'(e), int'(g), int'(s), eo, fo, ov, un);
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    m_in = m; lead_pos = lead; in_zero = z; exp_in = e; sign_in = sg; g_in = g; s_in = s;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("norm_in_ready", 32'(in_ready), 32'd0);
    chk("norm_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("round_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("exp_out", 32'(exp_out), 32'(eo));
    chk("frac_out", 32'(frac_out), 32'(fo));
    chk("sign_out", 32'(sign_out), 32'(sg));
    chk("ovf", 32'(ovf), 32'(ov));
    chk("unf", 32'(unf), 32'(un));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_exp", 32'(exp_out), 32'(eo));
      chk("hold_frac", 32'(frac_out), 32'(fo));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("drop_valid", 32'(out_valid), 32'd0);
    chk("back_in_ready", 32'(in_ready), 32'd1);
    $display("op m=%03h lead=%0d z=%0d e=%0d sg=%0d g=%0d s=%0d -> exp=%0d frac=%03h ovf=%0d unf=%0d",
             m, lead, z, e, sg, g, s, exp_out, frac_out, ovf, unf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rm;
    logic [3:0]  rl;
    logic        rz;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_exp", 32'(exp_out), 32'd0);
    chk("rst_frac", 32'(frac_out), 32'd0);
    chk("rst_flags", 32'({sign_out, ovf, unf}), 32'd0);
    rst = 1'b0;

    do_op(12'b010000000000, 4'd10, 1'b0, 5'd15, 1'b0, 1'b0, 1'b0, 0);
    do_op(12'b110000000001, 4'd11, 1'b0, 5'd15, 1'b0, 1'b0, 1'b0, 0);
    do_op(12'b000001100111, 4'd6,  1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 5);
    do_op(12'b011111111111, 4'd10, 1'b0, 5'd15, 1'b0, 1'b1, 1'b1, 0);
    do_op(12'b011111111111, 4'd10, 1'b0, 5'd30, 1'b1, 1'b1, 1'b1, 0);
    do_op(12'b000001100111, 4'd6,  1'b0, 5'd3,  1'b0, 1'b0, 1'b0, 0);
    do_op(12'b000000000000, 4'd0,  1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 0);
    do_op(12'b111111111111, 4'd11, 1'b0, 5'd30, 1'b0, 1'b1, 1'b0, 0);

    // Reset while the operand sits in ROUND must discard it.
    @(negedge clk);
    m_in = 12'b011111111111; lead_pos = 4'd10; in_zero = 1'b0; exp_in = 5'd20;
    sign_in = 1'b1; g_in = 1'b1; s_in = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_outputs", 32'({exp_out, frac_out, sign_out, ovf, unf}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_discard", 32'(out_valid), 32'd0);
    $display("op reset during ROUND");

    for (int n = 0; n < 150; n++) begin
      rz = ($urandom_range(0, 15) == 0);
      rl = 4'($urandom_range(0, 11));
      rm = 12'($urandom) & ((12'd1 << rl) - 12'd1);
      rm = rm | (12'd1 << rl);
      if (rz) begin
        rm = '0;
        rl = 4'($urandom_range(0, 11));
      end
      do_op(rm, rl, rz, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
